// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU command sequencer: FSM state encoding and FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: ALU_SEQ_CHAIN_EN (the chain bit of seq_entry_t is only stored when defined).
package alu_sequencer_pkg;

   localparam int OPC_W = 4;
   localparam int DAT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [DAT_W-1:0] a;
      logic [DAT_W-1:0] b;
      logic             chain;
   } seq_entry_t;

endpackage

// File: rtl/alu_sequencer_fifo.sv
// Command FIFO for the ALU sequencer: DEPTH entries of W bits, head visible combinationally.
// Latency: a push is visible at the head (and in empty_o) the cycle after it is written.
// Backpressure: full_o is derived from the registered count; the caller must not push when full.
// Ports: clk_i/rst_ni clock and async active-low reset, push_i/wdata_i write side,
//        pop_i/rdata_o read side, full_o/empty_o status.
module alu_seq_fifo
   import alu_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// ALU command sequencer: queues commands, issues each to an external ALU as a one-cycle Enable pulse,
// waits ALU_LAT cycles, then holds the captured result as a response until accepted.
// Latency: push to Rsp_Valid = ALU_LAT+2 cycles when idle; issue-to-issue spacing ALU_LAT+2 with Rsp_Ready high.
// Backpressure: Cmd_Ready = FIFO not full (registered count); Rsp_Valid held until Rsp_Ready.
// Optional feature macro: ALU_SEQ_CHAIN_EN -- Cmd_Chain=1 replaces A with the last accepted result.
// Ports: CLK/RST clock and async active-low reset; Cmd_* command input; Enable/Opcode/Data_A/Data_B
//        drive the ALU; Results/CF come back from it; Rsp_* response output; Busy activity flag.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Cmd_Valid,
   output logic             Cmd_Ready,
   input  logic [OPC_W-1:0] Cmd_Opcode,
   input  logic [DAT_W-1:0] Cmd_A,
   input  logic [DAT_W-1:0] Cmd_B,
   input  logic             Cmd_Chain,
   output logic             Enable,
   output logic [OPC_W-1:0] Opcode,
   output logic [DAT_W-1:0] Data_A,
   output logic [DAT_W-1:0] Data_B,
   input  logic [DAT_W-1:0] Results,
   input  logic             CF,
   output logic             Rsp_Valid,
   input  logic             Rsp_Ready,
   output logic [DAT_W-1:0] Rsp_Result,
   output logic             Rsp_CF,
   output logic             Busy
);

`ifdef ALU_SEQ_CHAIN_EN
   localparam int FIFO_W = $bits(seq_entry_t);
`else
   localparam int FIFO_W = $bits(seq_entry_t) - 1;
`endif

   seq_state_t       state_q;
   logic [1:0]       wait_cnt_q;
   logic             enable_q;
   logic [OPC_W-1:0] opcode_q;
   logic [DAT_W-1:0] data_a_q;
   logic [DAT_W-1:0] data_b_q;
   logic             rsp_valid_q;
   logic [DAT_W-1:0] rsp_result_q;
   logic             rsp_cf_q;

   logic [FIFO_W-1:0] fifo_wdata;
   logic [FIFO_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;

   logic [OPC_W-1:0] head_op;
   logic [DAT_W-1:0] head_a;
   logic [DAT_W-1:0] head_b;
   logic [DAT_W-1:0] issue_a;
   logic             issue_go;

`ifdef ALU_SEQ_CHAIN_EN
   logic [DAT_W-1:0] chain_q;
   seq_entry_t       push_entry;
   seq_entry_t       head_entry;

   assign push_entry = '{opcode: Cmd_Opcode, a: Cmd_A, b: Cmd_B, chain: Cmd_Chain};
   assign fifo_wdata = push_entry;
   assign head_entry = seq_entry_t'(fifo_rdata);
   assign head_op    = head_entry.opcode;
   assign head_a     = head_entry.a;
   assign head_b     = head_entry.b;
   // Issuing straight out of RESP happens on the same edge that loads chain_q, so take the
   // response register directly in that case.
   assign issue_a    = !head_entry.chain ? head_a :
                       (state_q == ST_RESP) ? rsp_result_q : chain_q;
`else
   logic unused_chain;

   assign unused_chain = Cmd_Chain;
   assign fifo_wdata   = {Cmd_Opcode, Cmd_A, Cmd_B};
   assign {head_op, head_a, head_b} = fifo_rdata;
   assign issue_a      = head_a;
`endif

   assign Cmd_Ready = !fifo_full;
   assign fifo_push = Cmd_Valid && Cmd_Ready;
   assign fifo_pop  = (state_q == ST_ISSUE);

   alu_seq_fifo #(
      .DEPTH (DEPTH),
      .W     (FIFO_W)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next edge enters ISSUE: from IDLE, or from RESP on the accepting edge.
   always_comb begin
      issue_go = 1'b0;
      if (!fifo_empty) begin
         issue_go = (state_q == ST_IDLE) || ((state_q == ST_RESP) && Rsp_Ready);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         wait_cnt_q   <= '0;
         enable_q     <= 1'b0;
         opcode_q     <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_cf_q     <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
         chain_q      <= '0;
`endif
      end else begin
         enable_q <= 1'b0;
         case (state_q)
            ST_ISSUE: begin
               state_q    <= ST_WAIT;
               wait_cnt_q <= 2'(ALU_LAT - 1);
            end
            ST_WAIT: begin
               if (wait_cnt_q == 2'd0) begin
                  rsp_result_q <= Results;
                  rsp_cf_q     <= CF;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 2'd1;
               end
            end
            ST_RESP: begin
               if (Rsp_Ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
`ifdef ALU_SEQ_CHAIN_EN
                  chain_q     <= rsp_result_q;
`endif
               end
            end
            default: ;
         endcase
         // Overrides the IDLE/RESP next state above when there is work to launch.
         if (issue_go) begin
            state_q  <= ST_ISSUE;
            enable_q <= 1'b1;
            opcode_q <= head_op;
            data_a_q <= issue_a;
            data_b_q <= head_b;
         end
      end
   end

   assign Enable     = enable_q;
   assign Opcode     = opcode_q;
   assign Data_A     = data_a_q;
   assign Data_B     = data_b_q;
   assign Rsp_Valid  = rsp_valid_q;
   assign Rsp_Result = rsp_result_q;
   assign Rsp_CF     = rsp_cf_q;
   assign Busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each driven by a registered adder model (Results = A+B, CF = carry-out).
// Chain expectations follow ALU_SEQ_CHAIN_EN when it is defined for the build.
module tb_alu_sequencer;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   // ALU_LAT = 1 instance
   logic        cmd_valid, cmd_ready, cmd_chain;
   logic [3:0]  cmd_opcode;
   logic [15:0] cmd_a, cmd_b;
   logic        enable;
   logic [3:0]  opcode;
   logic [15:0] data_a, data_b, results;
   logic        cf, rsp_valid, rsp_ready, rsp_cf, busy;
   logic [15:0] rsp_result;

   // ALU_LAT = 3 instance
   logic        cmd_valid3, cmd_ready3;
   logic [3:0]  cmd_opcode3;
   logic [15:0] cmd_a3, cmd_b3;
   logic        enable3;
   logic [3:0]  opcode3;
   logic [15:0] data_a3, data_b3, results3;
   logic        cf3, rsp_valid3, rsp_ready3, rsp_cf3, busy3;
   logic [15:0] rsp_result3;

   alu_sequencer #(.DEPTH(4), .ALU_LAT(1)) dut (
      .CLK(CLK), .RST(RST),
      .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready), .Cmd_Opcode(cmd_opcode),
      .Cmd_A(cmd_a), .Cmd_B(cmd_b), .Cmd_Chain(cmd_chain),
      .Enable(enable), .Opcode(opcode), .Data_A(data_a), .Data_B(data_b),
      .Results(results), .CF(cf),
      .Rsp_Valid(rsp_valid), .Rsp_Ready(rsp_ready), .Rsp_Result(rsp_result), .Rsp_CF(rsp_cf),
      .Busy(busy)
   );

   alu_sequencer #(.DEPTH(4), .ALU_LAT(3)) dut3 (
      .CLK(CLK), .RST(RST),
      .Cmd_Valid(cmd_valid3), .Cmd_Ready(cmd_ready3), .Cmd_Opcode(cmd_opcode3),
      .Cmd_A(cmd_a3), .Cmd_B(cmd_b3), .Cmd_Chain(1'b0),
      .Enable(enable3), .Opcode(opcode3), .Data_A(data_a3), .Data_B(data_b3),
      .Results(results3), .CF(cf3),
      .Rsp_Valid(rsp_valid3), .Rsp_Ready(rsp_ready3), .Rsp_Result(rsp_result3), .Rsp_CF(rsp_cf3),
      .Busy(busy3)
   );

   // Adder models: the sum only enters the pipe on an Enable cycle, zero otherwise.
   logic [16:0] alu1_q;
   logic [16:0] p0_q, p1_q, p2_q;
   always @(posedge CLK) begin
      alu1_q <= enable  ? ({1'b0, data_a}  + {1'b0, data_b})  : 17'h0;
      p0_q   <= enable3 ? ({1'b0, data_a3} + {1'b0, data_b3}) : 17'h0;
      p1_q   <= p0_q;
      p2_q   <= p1_q;
   end
   assign {cf, results}   = alu1_q;
   assign {cf3, results3} = p2_q;

   int          cyc = 0;
   int          en_cnt = 0;
   logic [15:0] last_da = '0;
   int          en3_n = 0;
   int          en3_t [8];
   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) begin
      if (enable) begin
         en_cnt  <= en_cnt + 1;
         last_da <= data_a;
      end
      if (enable3 && en3_n < 8) begin
         en3_t[en3_n] <= cyc;
         en3_n        <= en3_n + 1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic push1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ch);
      int n;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = ch;
      n = 0;
      while (!cmd_ready && n < 100) begin tick; n++; end
      tick;
      cmd_valid = 1'b0; cmd_chain = 1'b0;
   endtask

   task automatic push3(input logic [15:0] a, input logic [15:0] b);
      int n;
      cmd_valid3 = 1'b1; cmd_opcode3 = 4'h1; cmd_a3 = a; cmd_b3 = b;
      n = 0;
      while (!cmd_ready3 && n < 100) begin tick; n++; end
      tick;
      cmd_valid3 = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 60) begin tick; n++; end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        cf;
   } vec_t;

   vec_t vecs [6];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n, k, e0, extra;
      logic [15:0] got [5];
      logic [15:0] exp_v;

      vecs[0] = '{4'h1, 16'h0003, 16'h0004, 16'h0007, 1'b0};
      vecs[1] = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
      vecs[2] = '{4'h2, 16'h8000, 16'h8000, 16'h0000, 1'b1};
      vecs[3] = '{4'h3, 16'h1234, 16'h1111, 16'h2345, 1'b0};
      vecs[4] = '{4'h7, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
      vecs[5] = '{4'hF, 16'h0000, 16'h0000, 16'h0000, 1'b0};

      cmd_valid = 0; cmd_chain = 0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 0;
      cmd_valid3 = 0; cmd_opcode3 = '0; cmd_a3 = '0; cmd_b3 = '0; rsp_ready3 = 0;

      // ---- reset state ----
      #2 RST = 1'b0;
      #10;
      check("rst_cmd_ready",  cmd_ready,  1);
      check("rst_rsp_valid",  rsp_valid,  0);
      check("rst_enable",     enable,     0);
      check("rst_busy",       busy,       0);
      check("rst_opcode",     opcode,     0);
      check("rst_data_a",     data_a,     0);
      check("rst_data_b",     data_b,     0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_cf",     rsp_cf,     0);
      @(negedge CLK) RST = 1'b1;
      tick;

      // ---- single commands from the table ----
      for (int i = 0; i < 6; i++) begin
         e0 = en_cnt;
         push1(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
         wait_rsp(n);
         check($sformatf("v%0d_latency", i), n, 3);
         check($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
         check($sformatf("v%0d_cf", i), rsp_cf, vecs[i].cf);
         check($sformatf("v%0d_enable_pulses", i), en_cnt - e0, 1);
         tick;
         check($sformatf("v%0d_hold_valid", i), rsp_valid, 1);
         check($sformatf("v%0d_hold_result", i), rsp_result, vecs[i].res);
         rsp_ready = 1'b1;
         tick;
         rsp_ready = 1'b0;
         check($sformatf("v%0d_valid_drop", i), rsp_valid, 0);
         check($sformatf("v%0d_opcode_hold", i), {enable, opcode}, {1'b0, vecs[i].op});
         tick;
      end

      // ---- back-pressure: 5 commands into DEPTH=4 with Rsp_Ready low ----
      for (int i = 0; i < 5; i++) begin
         push1(4'h1, 16'(16'h0100 * (i + 1)), 16'(i + 1), 1'b0);
      end
      check("bp_cmd_ready_full", cmd_ready, 0);
      check("bp_busy", busy, 1);
      rsp_ready = 1'b1;
      k = 0; n = 0;
      while (k < 5 && n < 200) begin
         if (rsp_valid) begin got[k] = rsp_result; k++; end
         tick; n++;
      end
      check("bp_count", k, 5);
      for (int i = 0; i < 5; i++) begin
         exp_v = 16'(16'h0101 * (i + 1));
         check($sformatf("bp_order%0d", i), got[i], exp_v);
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) extra++;
         tick;
      end
      rsp_ready = 1'b0;
      check("bp_no_duplicate", extra, 0);
      check("bp_idle_busy", busy, 0);

      // ---- reset while the first of three commands is in WAIT ----
      cmd_valid = 1'b1; cmd_opcode = 4'h1; cmd_a = 16'd10; cmd_b = 16'd1;
      tick;
      cmd_a = 16'd20;
      tick;
      cmd_a = 16'd30;
      tick;
      cmd_valid = 1'b0;
      check("mid_busy_before", busy, 1);
      RST = 1'b0;
      #1;
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_busy", busy, 0);
      check("mid_enable", enable, 0);
      @(negedge CLK) RST = 1'b1;
      tick;
      check("mid_cmd_ready", cmd_ready, 1);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid || enable) extra++;
         tick;
      end
      check("mid_discarded", extra, 0);
      push1(4'h1, 16'h0001, 16'h0001, 1'b0);
      wait_rsp(n);
      check("mid_new_result", rsp_result, 16'h0002);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;

      // ---- chained command ----
      rsp_ready = 1'b1;
      push1(4'h1, 16'h0005, 16'h0003, 1'b0);
      push1(4'h1, 16'hDEAD, 16'h0002, 1'b1);
      k = 0; n = 0;
      while (k < 2 && n < 100) begin
         if (rsp_valid) begin got[k] = rsp_result; k++; end
         tick; n++;
      end
      rsp_ready = 1'b0;
      check("chain_first", got[0], 16'h0008);
`ifdef ALU_SEQ_CHAIN_EN
      check("chain_data_a", last_da, 16'h0008);
      check("chain_second", got[1], 16'h000A);
`else
      check("nochain_data_a", last_da, 16'hDEAD);
      check("nochain_second", got[1], 16'hDEAF);
`endif

      // ---- ALU_LAT=3 streaming: issue spacing ----
      rsp_ready3 = 1'b1;
      push3(16'h0002, 16'h0003);
      push3(16'hFFF0, 16'h0020);
      push3(16'h1000, 16'h0234);
      k = 0; n = 0;
      while (k < 3 && n < 100) begin
         if (rsp_valid3) begin got[k] = rsp_result3; k++; end
         tick; n++;
      end
      for (int i = 0; i < 5; i++) tick;
      rsp_ready3 = 1'b0;
      check("lat3_pulses", en3_n, 3);
      check("lat3_gap01", en3_t[1] - en3_t[0], 5);
      check("lat3_gap12", en3_t[2] - en3_t[1], 5);
      check("lat3_res0", got[0], 16'h0005);
      check("lat3_res1", got[1], 16'h0010);
      check("lat3_res2", got[2], 16'h1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries; power of two, 2..16.
REQ-002 Parameter ALU_LAT, default 1: cycles from the ALU Enable cycle to valid Results/CF; range 1..4.
REQ-003 CLK  in  1  single clock; all state rising-edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 Cmd_Valid  in  1  command offered.
REQ-006 Cmd_Ready  out  1  command accepted when high with Cmd_Valid.
REQ-007 Cmd_Opcode  in  4  ALU opcode.
REQ-008 Cmd_A, Cmd_B  in  16 each  operands.
REQ-009 Cmd_Chain  in  1  use previous result as A; meaningful only with ALU_SEQ_CHAIN_EN.
REQ-010 Enable, Opcode, Data_A, Data_B  out  1/4/16/16  drive the ALU.
REQ-011 Results, CF  in  16/1  ALU result and carry/overflow.
REQ-012 Rsp_Valid  out  1  response held; Rsp_Ready  in  1  consumer accepts.
REQ-013 Rsp_Result, Rsp_CF  out  16/1  captured ALU outputs.
REQ-014 Busy  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-015 Cmd_Ready SHALL be high iff the registered FIFO count < DEPTH; no same-cycle full bypass.
REQ-016 A push SHALL occur on Cmd_Valid&&Cmd_Ready; the FIFO SHALL be first-in first-out with pointer wrap modulo DEPTH.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE->ISSUE when the FIFO is non-empty; a command pushed while empty SHALL take ISSUE no earlier than the next cycle.
REQ-019 In ISSUE, Enable SHALL be high for exactly one cycle, Opcode/Data_A/Data_B SHALL carry the FIFO head, and the head SHALL pop; then ->WAIT.
REQ-020 WAIT SHALL last ALU_LAT cycles via a down-counter; on its last cycle Results/CF SHALL be registered into Rsp_Result/Rsp_CF; then ->RESP.
REQ-021 In RESP, Rsp_Valid SHALL be high and Rsp_Result/Rsp_CF stable until Rsp_Ready; on acceptance ->ISSUE if FIFO non-empty, else ->IDLE.
REQ-022 Rsp_Valid SHALL NOT depend combinationally on Rsp_Ready.
REQ-023 Enable SHALL be low and Opcode/Data_A/Data_B SHALL hold their last value outside ISSUE.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged; push into a full FIFO is impossible by REQ-015.
REQ-025 Minimum issue-to-issue spacing SHALL be ALU_LAT+2 cycles with Rsp_Ready held high.

Reset
REQ-026 On RST low, asynchronously: FSM=IDLE, FIFO count/pointers=0, Enable=0, Opcode=0, Data_A=0, Data_B=0, Rsp_Valid=0, Rsp_Result=0, Rsp_CF=0, WAIT counter=0, chain register=0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight commands with no response produced; Cmd_Ready SHALL be high from the first cycle after reset release.

Configuration
REQ-028 Macro ALU_SEQ_CHAIN_EN: when defined, a chain register SHALL load Rsp_Result on each response acceptance, and a command with Cmd_Chain=1 SHALL drive Data_A from that register instead of Cmd_A in ISSUE.
REQ-029 Without ALU_SEQ_CHAIN_EN, Cmd_Chain SHALL be ignored, Cmd_Chain SHALL not be stored in the FIFO, and no chain register SHALL exist.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (2-bit encoding) and the FIFO entry struct (opcode, A, B, chain).
REQ-031 The FIFO SHALL be one sub-module, alu_seq_fifo, parameterised by DEPTH and entry width; the FSM and ALU drive logic SHALL live in alu_sequencer.

Verification (bench ALU model: registered, Results=A+B, CF=carry-out, latency ALU_LAT)
REQ-032 Single command, Opcode=4'h1, A=16'h0003, B=16'h0004, ALU_LAT=1 -> one Enable pulse; Rsp_Valid 3 cycles after push acceptance; Rsp_Result=16'h0007, Rsp_CF=0.
REQ-033 Carry: A=16'hFFFF, B=16'h0001 -> Rsp_Result=16'h0000, Rsp_CF=1.
REQ-034 Back-pressure: push 5 commands with DEPTH=4 and Rsp_Ready=0 -> Cmd_Ready low once the FIFO is full; after Rsp_Ready=1, all 5 responses are delivered in order with no loss or duplication.
REQ-035 Reset mid-WAIT with 2 commands queued -> Rsp_Valid=0, Busy=0 and Enable=0 after reset; new command A=1, B=1 -> Rsp_Result=16'h0002.
REQ-036 ALU_SEQ_CHAIN_EN: command A=5, B=3, then command Cmd_Chain=1, Cmd_A=16'hDEAD, B=2 -> second ALU Data_A=16'h0008, Rsp_Result=16'h000A.
REQ-037 ALU_LAT=3, streaming commands with Rsp_Ready=1 -> Enable pulses exactly 5 cycles apart.
